syst_array_ctrl: RTL



---
 rtl/syst_array_pkg.sv | 20 ++
 rtl/syst_skew_line.sv | 25 ++
 rtl/syst_array_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/syst_array_pkg.sv
// Shared types and timing constants for the systolic array sequencer.
// No logic, so no latency and no backpressure.
package syst_array_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FEED,
        S_DRAIN,
        S_DONE
    } ctrl_state_t;

    localparam int BUF_RD_LAT = 1;

    // Cycles to wait after the last activation read so skew valids and partial sums flush.
    function automatic int drain_len(input int rows, input int cols);
        return rows + cols;
    endfunction

endpackage

// File: rtl/syst_skew_line.sv
// Valid delay chain: dout[i] is din delayed i+1 cycles; sync clear empties the chain.
// Latency 1..N cycles; no backpressure, free-running shift.
module syst_skew_line #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         din,
    output logic [N-1:0] dout
);

    logic [N:0] shifted;

    assign shifted = {dout, din};

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            dout <= '0;
        end else begin
            dout <= shifted[N-1:0];
        end
    end

endmodule

// File: rtl/syst_array_ctrl.sv
// Weight-stationary systolic array sequencer: load weights, stream M vectors, drain, pulse done.
// Strobes are decoded from state (0 cycles), valids lag reads by 1+r; no backpressure. Option: SYST_CTRL_PERF_EN.
module syst_array_ctrl
    import syst_array_pkg::*;
#(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int M_WIDTH  = 16,
    parameter int A_ADDR_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    input  logic                    i_abort,
    input  logic [M_WIDTH-1:0]      i_m_len,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_wbuf_rd,
    output logic [$clog2(ROWS)-1:0] o_wbuf_addr,
    output logic                    o_w_vld,
    output logic [ROWS-1:0]         o_we_row,
    output logic                    o_abuf_rd,
    output logic [A_ADDR_W-1:0]     o_abuf_addr,
    output logic [ROWS-1:0]         o_a_vld
`ifdef SYST_CTRL_PERF_EN
    ,
    output logic [31:0]             o_perf_cycles
`endif
);

    localparam int WA_W  = $clog2(ROWS);
    localparam int DRAIN = drain_len(ROWS, COLS);
    localparam int CNT_W = A_ADDR_W + $clog2(2 * ROWS + COLS) + 1;

    ctrl_state_t        state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [M_WIDTH-1:0] m_len;
    logic               busy, accept, abort_clr;
    logic               wbuf_rd, abuf_rd, done;
    logic [ROWS-1:0]    we_row;
    logic [BUF_RD_LAT-1:0]      w_dly;
    logic [ROWS+BUF_RD_LAT-2:0] a_dly;

    assign busy      = (state != S_IDLE);
    assign accept    = (state == S_IDLE) && i_start && !i_abort;
    assign abort_clr = busy && i_abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            m_len <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                m_len <= i_m_len;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = (cnt == '1) ? cnt : cnt + 1'b1;
        wbuf_rd   = 1'b0;
        abuf_rd   = 1'b0;
        we_row    = '0;
        done      = 1'b0;
        unique case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (accept) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                wbuf_rd = (cnt < CNT_W'(ROWS));
                // Row r latches at k=2r+1: one buffer cycle plus r hops down the column.
                for (int r = 0; r < ROWS; r++) begin
                    if (cnt == CNT_W'(2 * r + 1)) begin
                        we_row[r] = 1'b1;
                    end
                end
                if (cnt == CNT_W'(2 * ROWS - 1)) begin
                    state_nxt = (m_len == '0) ? S_DONE : S_FEED;
                    cnt_nxt   = '0;
                end
            end
            S_FEED: begin
                abuf_rd = 1'b1;
                if (cnt == CNT_W'(m_len) - CNT_W'(1)) begin
                    state_nxt = S_DRAIN;
                    cnt_nxt   = '0;
                end
            end
            S_DRAIN: begin
                if (cnt == CNT_W'(DRAIN - 1)) begin
                    state_nxt = S_DONE;
                    cnt_nxt   = '0;
                end
            end
            S_DONE: begin
                done      = !i_abort;
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
        if (abort_clr) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
        end
    end

    syst_skew_line #(.N(BUF_RD_LAT)) u_w_line (
        .clk  (clk),
        .rst  (rst),
        .clr  (abort_clr),
        .din  (wbuf_rd),
        .dout (w_dly)
    );

    syst_skew_line #(.N(ROWS + BUF_RD_LAT - 1)) u_a_line (
        .clk  (clk),
        .rst  (rst),
        .clr  (abort_clr),
        .din  (abuf_rd),
        .dout (a_dly)
    );

    assign o_busy      = busy;
    assign o_done      = done;
    assign o_wbuf_rd   = wbuf_rd;
    assign o_wbuf_addr = wbuf_rd ? cnt[WA_W-1:0] : '0;
    assign o_w_vld     = w_dly[BUF_RD_LAT-1];
    assign o_we_row    = we_row;
    assign o_abuf_rd   = abuf_rd;
    assign o_abuf_addr = abuf_rd ? cnt[A_ADDR_W-1:0] : '0;
    assign o_a_vld     = a_dly[ROWS+BUF_RD_LAT-2 -: ROWS];

`ifdef SYST_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            o_perf_cycles <= '0;
        end else if (busy && o_perf_cycles != '1) begin
            o_perf_cycles <= o_perf_cycles + 32'd1;
        end
    end
`endif

endmodule
